// File: rtl/dram_responder.sv
// Single-port 16 x 8 memory responder: one write or one read in flight at a time,
// with pulsed write-commit, read-valid and illegal-request indications.
module dram_responder #(
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dram_out,
  input  logic       dram_in,
  input  logic [3:0] pointer,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       wack,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [3:0]  addr_reg;
  logic [7:0]  data_reg;
  logic [7:0]  mem [16];
  logic [15:0] word_we;

  logic accept_wr, accept_rd, illegal, commit, deliver;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept_wr  = 1'b0;
    accept_rd  = 1'b0;
    illegal    = 1'b0;
    commit     = 1'b0;
    deliver    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (en) begin
          if (dram_out && !dram_in) begin
            accept_wr  = 1'b1;
            state_next = WRITE;
          end else if (dram_in && !dram_out) begin
            accept_rd  = 1'b1;
            state_next = READ;
            cnt_next   = 2'(RD_LAT - 1);
          end else if (dram_in && dram_out) begin
            illegal = 1'b1;
          end
        end
      end
      WRITE: begin
        commit     = 1'b1;
        state_next = IDLE;
      end
      READ: begin
        // Counter reaches zero on the edge that must present the data.
        if (cnt_reg == 2'd0) begin
          deliver    = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
      addr_reg  <= 4'd0;
      data_reg  <= 8'd0;
      rdata     <= 8'd0;
      rvalid    <= 1'b0;
      wack      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept_wr || accept_rd) begin
        addr_reg <= pointer;
      end
      if (accept_wr) begin
        data_reg <= wdata;
      end
      if (deliver) begin
        rdata <= mem[addr_reg];
      end
      rvalid <= deliver;
      wack   <= commit;
      err    <= illegal;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_we
      assign word_we[gi] = commit && (addr_reg == 4'(gi));
    end
  endgenerate

  // Reset clears the whole array, so a write aborted by reset can never land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (word_we[i]) begin
          mem[i] <= data_reg;
        end
      end
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_dram_responder.sv
// Scoreboard bench for dram_responder built with a three-cycle read latency.
module tb_dram_responder;

  localparam int RD_LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       dram_out = 1'b0;
  logic       dram_in = 1'b0;
  logic [3:0] pointer = 4'd0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] rdata;
  logic       rvalid, wack, busy, err;

  dram_responder #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dram_out(dram_out), .dram_in(dram_in),
    .pointer(pointer), .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
    .wack(wack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_WACK, EV_RVALID, EV_ERR} ev_t;
  typedef struct {
    ev_t        kind;
    logic [7:0] data;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model[16];
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic exp_t mk(input ev_t k, input logic [7:0] d, input int l);
    exp_t e;
    e.kind = k;
    e.data = d;
    e.lat  = l;
    return e;
  endfunction

  // Drive one request from the current point, hold it over one rising edge, then
  // scramble pointer/wdata so the in-flight access must rely on its captured copy.
  task automatic issue(input logic wr, input logic rd, input logic [3:0] p, input logic [7:0] d);
    en = 1'b1; dram_out = wr; dram_in = rd; pointer = p; wdata = d;
    @(posedge clk); #1;
    en = 1'b0; dram_out = 1'b0; dram_in = 1'b0; pointer = ~p; wdata = ~d;
  endtask

  // Returns the number of edges after acceptance at which the pulse was seen, -1 if never.
  task automatic wait_pulse(input ev_t kind, input int start, input int window, output int lat);
    lat = -1;
    for (int i = start; i < start + window; i++) begin
      @(negedge clk);
      if ((kind == EV_WACK && wack) || (kind == EV_RVALID && rvalid) || (kind == EV_ERR && err)) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++;
    if ({rdata, rvalid, wack, busy, err} !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: got rdata=%h rvalid=%b wack=%b busy=%b err=%b want all zero",
               rdata, rvalid, wack, busy, err);
    end
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  task automatic test_post_reset_read;
    exp_t e; int lat;
    sb.push_back(mk(EV_RVALID, model[1], RD_LAT));
    issue(1'b0, 1'b1, 4'd1, 8'h00);
    wait_pulse(EV_RVALID, 0, 10, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat || rdata !== e.data) begin
      n_bad++;
      $display("FAIL post_reset_read: got lat=%0d rdata=%h want lat=%0d rdata=%h", lat, rdata, e.lat, e.data);
    end
    $display("read ptr=1 lat=%0d rdata=%h", lat, rdata);
  endtask

  task automatic test_write_read;
    exp_t e; int lat;
    @(negedge clk);
    model[0] = 8'h80;
    sb.push_back(mk(EV_WACK, 8'h00, 1));
    issue(1'b1, 1'b0, 4'd0, 8'h80);
    wait_pulse(EV_WACK, 0, 8, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_bad++;
      $display("FAIL write_wack_lat: got %0d want %0d", lat, e.lat);
    end
    $display("write ptr=0 data=80 wack lat=%0d", lat);
    @(negedge clk);
    sb.push_back(mk(EV_RVALID, model[0], RD_LAT));
    issue(1'b0, 1'b1, 4'd0, 8'h00);
    wait_pulse(EV_RVALID, 0, 10, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat || rdata !== e.data) begin
      n_bad++;
      $display("FAIL write_read: got lat=%0d rdata=%h want lat=%0d rdata=%h", lat, rdata, e.lat, e.data);
    end
    $display("read ptr=0 lat=%0d rdata=%h", lat, rdata);
    @(negedge clk);
    n_cmp++;
    if (rvalid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rvalid_width: got rvalid=%b busy=%b want 0 0", rvalid, busy);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e; int lat;
    @(negedge clk);
    model[3] = 8'h5A;
    sb.push_back(mk(EV_WACK, 8'h00, 1));
    issue(1'b1, 1'b0, 4'd3, 8'h5A);
    wait_pulse(EV_WACK, 0, 8, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_bad++;
      $display("FAIL b2b_wack_lat: got %0d want %0d", lat, e.lat);
    end
    // Still inside the wack cycle: the read must be accepted on the very next edge.
    sb.push_back(mk(EV_RVALID, model[3], RD_LAT));
    issue(1'b0, 1'b1, 4'd3, 8'h00);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_busy: got %b want 1", busy);
    end
    en = 1'b1; dram_out = 1'b1; pointer = 4'd3; wdata = 8'h11;
    @(negedge clk);
    en = 1'b0; dram_out = 1'b0;
    wait_pulse(EV_RVALID, 2, 8, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat || rdata !== e.data) begin
      n_bad++;
      $display("FAIL b2b_read: got lat=%0d rdata=%h want lat=%0d rdata=%h", lat, rdata, e.lat, e.data);
    end
    $display("b2b read ptr=3 lat=%0d rdata=%h", lat, rdata);
    wait_pulse(EV_WACK, 0, 6, lat);
    n_cmp++;
    if (lat !== -1) begin
      n_bad++;
      $display("FAIL busy_ignored: got wack at %0d want none", lat);
    end
    sb.push_back(mk(EV_RVALID, model[3], RD_LAT));
    issue(1'b0, 1'b1, 4'd3, 8'h00);
    wait_pulse(EV_RVALID, 0, 10, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat || rdata !== e.data) begin
      n_bad++;
      $display("FAIL b2b_reread: got lat=%0d rdata=%h want lat=%0d rdata=%h", lat, rdata, e.lat, e.data);
    end
    $display("reread ptr=3 lat=%0d rdata=%h", lat, rdata);
  endtask

  task automatic test_illegal;
    exp_t e; int lat;
    @(negedge clk);
    sb.push_back(mk(EV_ERR, 8'h00, 0));
    issue(1'b1, 1'b1, 4'd0, 8'h33);
    wait_pulse(EV_ERR, 0, 4, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_err: got lat=%0d busy=%b want lat=%0d busy=0", lat, busy, e.lat);
    end
    $display("illegal request err lat=%0d", lat);
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b0 || wack !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_width: got err=%b busy=%b wack=%b want 0 0 0", err, busy, wack);
    end
    sb.push_back(mk(EV_RVALID, model[0], RD_LAT));
    issue(1'b0, 1'b1, 4'd0, 8'h00);
    wait_pulse(EV_RVALID, 0, 10, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat || rdata !== e.data) begin
      n_bad++;
      $display("FAIL illegal_reread: got lat=%0d rdata=%h want lat=%0d rdata=%h", lat, rdata, e.lat, e.data);
    end
    $display("reread ptr=0 lat=%0d rdata=%h", lat, rdata);
  endtask

  task automatic test_en_drop;
    exp_t e; int lat;
    @(negedge clk);
    model[15] = 8'hC3;
    sb.push_back(mk(EV_WACK, 8'h00, 1));
    issue(1'b1, 1'b0, 4'd15, 8'hC3);
    wait_pulse(EV_WACK, 0, 8, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin
      n_bad++;
      $display("FAIL wrap_wack_lat: got %0d want %0d", lat, e.lat);
    end
    @(negedge clk);
    sb.push_back(mk(EV_RVALID, model[15], RD_LAT));
    issue(1'b0, 1'b1, 4'd15, 8'h00);
    wait_pulse(EV_RVALID, 0, 10, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat || rdata !== e.data) begin
      n_bad++;
      $display("FAIL en_drop_read: got lat=%0d rdata=%h want lat=%0d rdata=%h", lat, rdata, e.lat, e.data);
    end
    $display("en-drop read ptr=15 lat=%0d rdata=%h", lat, rdata);
  endtask

  task automatic test_reset_mid_write;
    exp_t e; int lat;
    @(negedge clk);
    issue(1'b1, 1'b0, 4'd7, 8'hFF);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    n_cmp++;
    if ({rdata, rvalid, wack, busy, err} !== 12'h000) begin
      n_bad++;
      $display("FAIL async_reset: got rdata=%h rvalid=%b wack=%b busy=%b err=%b want all zero",
               rdata, rvalid, wack, busy, err);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    wait_pulse(EV_WACK, 0, 5, lat);
    n_cmp++;
    if (lat !== -1) begin
      n_bad++;
      $display("FAIL aborted_write_wack: got wack at %0d want none", lat);
    end
    sb.push_back(mk(EV_RVALID, model[7], RD_LAT));
    issue(1'b0, 1'b1, 4'd7, 8'h00);
    wait_pulse(EV_RVALID, 0, 10, lat);
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat || rdata !== e.data) begin
      n_bad++;
      $display("FAIL aborted_write_read: got lat=%0d rdata=%h want lat=%0d rdata=%h", lat, rdata, e.lat, e.data);
    end
    $display("read after aborted write ptr=7 lat=%0d rdata=%h", lat, rdata);
  endtask

  // Background checks: rdata only moves with rvalid, and the three pulses stay exclusive.
  initial begin
    logic [7:0] prev_rdata;
    logic       prev_rst;
    prev_rdata = 8'h00;
    prev_rst   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && prev_rst) begin
        if (!rvalid && rdata !== prev_rdata) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rdata_stable: got %h want %h", rdata, prev_rdata);
        end
        if (rvalid || wack || err) begin
          n_cmp++;
          if (int'(rvalid) + int'(wack) + int'(err) > 1) begin
            n_bad++;
            $display("FAIL pulse_exclusive: got rvalid=%b wack=%b err=%b want at most one", rvalid, wack, err);
          end
        end
      end
      prev_rdata = rdata;
      prev_rst   = rst_n;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_post_reset_read();
    test_write_read();
    test_back_to_back();
    test_illegal();
    test_en_drop();
    test_reset_mid_write();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
Parameters:
REQ-001 The block SHALL have parameter RD_LAT, default 2, legal 1..4, giving the cycles from read acceptance to read data valid.
Ports:
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port en, input, 1 bit: request enable; requests are considered only while high.
REQ-005 The block SHALL have port dram_out, input, 1 bit: write strobe, requester pushes wdata into memory.
REQ-006 The block SHALL have port dram_in, input, 1 bit: read strobe, requester pulls memory data into its buffer.
REQ-007 The block SHALL have port pointer, input, 4 bits: word address, 16 locations.
REQ-008 The block SHALL have port wdata, input, 8 bits: write data.
REQ-009 The block SHALL have port rdata, output, 8 bits: read data, registered, holds last read value.
REQ-010 The block SHALL have port rvalid, output, 1 bit: one-cycle pulse marking rdata updated.
REQ-011 The block SHALL have port wack, output, 1 bit: one-cycle pulse marking write committed.
REQ-012 The block SHALL have port busy, output, 1 bit: high while an accepted access is in progress.
REQ-013 The block SHALL have port err, output, 1 bit: one-cycle pulse on an illegal request (both strobes high).

Function
REQ-014 Storage SHALL be a 16 x 8-bit register array inside the block.
REQ-015 The FSM SHALL have states IDLE, WRITE and READ; busy SHALL be 1 exactly when the state is not IDLE.
REQ-016 Acceptance SHALL occur only in IDLE at a rising edge where en=1 and exactly one strobe is 1; pointer/wdata SHALL be captured at that edge.
REQ-017 Write accepted at edge k: state WRITE; mem[pointer] updated at edge k+1; wack=1 for the single cycle after edge k+1; state returns to IDLE at edge k+1.
REQ-018 Read accepted at edge k: state READ; internal latency counter loaded; rdata=mem[addr] and rvalid=1 after edge k+RD_LAT for one cycle; state returns to IDLE at that edge.
REQ-019 A new request SHALL be acceptable in the wack/rvalid cycle (earliest edge k+2 for write, k+RD_LAT+1 for read).
REQ-020 Requests while busy=1 SHALL be ignored, not queued; the requester re-issues them.
REQ-021 en falling mid-access SHALL NOT abort it; the access completes and acks normally.
REQ-022 en=1 with dram_in=1 and dram_out=1 in IDLE SHALL cause err=1 for the next cycle, no memory access and no state change.
REQ-023 Pointer/wdata changes after acceptance SHALL NOT affect the access in flight.
REQ-024 A read following a write to the same address SHALL return the newly written value.
REQ-025 rdata SHALL change only on rvalid cycles; wack, rvalid and err SHALL never be high together.
REQ-026 Pointer values wrap naturally over 4 bits; no out-of-range condition exists.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, all 16 memory words to 0x00, rdata=0x00 and rvalid=wack=busy=err=0.
REQ-028 Reset during an access SHALL abort it: a write not yet committed SHALL NOT reach memory, and no ack SHALL follow.
REQ-029 The first acceptance after release SHALL be at the first rising edge with rst_n=1.

Verification
REQ-030 Write then read: write 0x80 at pointer 0 -> wack one cycle after commit; read pointer 0 -> rdata=0x80, rvalid exactly RD_LAT cycles after acceptance.
REQ-031 Post-reset read: read pointer 1 before any write -> rdata=0x00 with rvalid.
REQ-032 Back-to-back: write 0x5A at pointer 3, re-assert read of pointer 3 in the wack cycle -> accepted; rdata=0x5A; a request raised while busy produces no ack.
REQ-033 Illegal strobe: dram_in=dram_out=1, en=1 -> err pulse one cycle, busy stays 0, memory unchanged (verified by reread).
REQ-034 Reset mid-write: accept write 0xFF at pointer 7, assert rst_n=0 before commit -> no wack; later read of pointer 7 -> 0x00.
REQ-035 en dropped mid-read with RD_LAT=3: en low after acceptance -> rvalid still after 3 cycles with correct data.
